rx_sync_ctrl: RTL and testbench

RX_SYNC_CTRL -- requirements
Module: rx_sync_ctrl

---
 rtl/rx_sync_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_rx_sync_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_sync_ctrl.sv
// 8b/10b receive synchroniser: running-disparity tracking, comma-based lock FSM,
// per-symbol error flags and a one-deep forwarding register. Optional error counter: RX_ERR_CNT_EN.
module rx_sync_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sym_in,
    input  logic       sym_valid,
    output logic       sym_ready,
    output logic [9:0] sym_out,
    output logic       rd_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       sync,
    output logic       code_err,
    output logic       disp_err,
    output logic [7:0] err_cnt,
    input  logic       clr_cnt,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_LOS  = 2'd0,
        ST_CD1  = 2'd1,
        ST_CD2  = 2'd2,
        ST_SYNC = 2'd3
    } state_t;

    localparam logic [9:0] COMMA_NEG = 10'b0011111010;
    localparam logic [9:0] COMMA_POS = 10'b1100000101;

    state_t     state_q, state_d;
    logic       rd_q, rd_d;
    logic [1:0] bad_q, bad_d;
    logic [1:0] good_q, good_d;
    logic       out_valid_q, out_valid_d;
    logic [9:0] sym_out_q, sym_out_d;
    logic       rd_out_q, rd_out_d;
    logic       code_err_q, code_err_d;
    logic       disp_err_q, disp_err_d;

    logic [3:0] ones;
    logic       accept;
    logic       is_comma;
    logic       sym_code_err;
    logic       sym_disp_err;
    logic       sym_err;

    // Handshake: a symbol moves when sym_valid & sym_ready; the output word
    // moves when out_valid & out_ready. sym_ready frees up in the same cycle
    // the pending word drains, so there is no bubble.
    assign sym_ready = !out_valid_q || out_ready;
    assign accept    = sym_valid && sym_ready;
    assign is_comma  = (sym_in == COMMA_NEG) || (sym_in == COMMA_POS);

    always_comb begin
        ones = 4'd0;
        for (int i = 0; i < 10; i++) begin
            ones = ones + {3'b000, sym_in[i]};
        end
    end

    assign sym_code_err = (ones != 4'd4) && (ones != 4'd5) && (ones != 4'd6);
    assign sym_disp_err = ((ones == 4'd6) && rd_q) || ((ones == 4'd4) && !rd_q);
    assign sym_err      = sym_code_err || sym_disp_err;

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        bad_d       = bad_q;
        good_d      = good_q;
        out_valid_d = out_valid_q;
        sym_out_d   = sym_out_q;
        rd_out_d    = rd_out_q;
        code_err_d  = 1'b0;
        disp_err_d  = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            code_err_d = sym_code_err;
            disp_err_d = sym_disp_err;
            if (!sym_code_err) begin
                if (ones == 4'd6) begin
                    rd_d = 1'b1;
                end else if (ones == 4'd4) begin
                    rd_d = 1'b0;
                end
            end

            // Only symbols seen while already locked go downstream, tagged with the pre-symbol RD.
            if (state_q == ST_SYNC) begin
                out_valid_d = 1'b1;
                sym_out_d   = sym_in;
                rd_out_d    = rd_q;
            end

            case (state_q)
                ST_LOS: begin
                    if (!sym_err && is_comma) state_d = ST_CD1;
                end
                ST_CD1: begin
                    if (sym_err) state_d = ST_LOS;
                    else if (is_comma) state_d = ST_CD2;
                end
                ST_CD2: begin
                    if (sym_err) state_d = ST_LOS;
                    else if (is_comma) state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    if (sym_err) begin
                        good_d = 2'd0;
                        if (bad_q == 2'd2) begin
                            state_d = ST_LOS;
                            bad_d   = 2'd0;
                        end else begin
                            bad_d = bad_q + 2'd1;
                        end
                    end else if (good_q == 2'd3) begin
                        good_d = 2'd0;
                        bad_d  = 2'd0;
                    end else begin
                        good_d = good_q + 2'd1;
                    end
                end
                default: state_d = ST_LOS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_LOS;
            rd_q        <= 1'b0;
            bad_q       <= 2'd0;
            good_q      <= 2'd0;
            out_valid_q <= 1'b0;
            sym_out_q   <= 10'd0;
            rd_out_q    <= 1'b0;
            code_err_q  <= 1'b0;
            disp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            bad_q       <= bad_d;
            good_q      <= good_d;
            out_valid_q <= out_valid_d;
            sym_out_q   <= sym_out_d;
            rd_out_q    <= rd_out_d;
            code_err_q  <= code_err_d;
            disp_err_q  <= disp_err_d;
        end
    end

`ifdef RX_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Clear beats a same-cycle increment; the count saturates rather than wraps.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = 8'd0;
        end else if (accept && sym_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_cnt_q <= 8'd0;
        else      err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign err_cnt        = 8'd0;
`endif

    assign out_valid = out_valid_q;
    assign sym_out   = sym_out_q;
    assign rd_out    = rd_out_q;
    assign code_err  = code_err_q;
    assign disp_err  = disp_err_q;
    assign sync      = (state_q == ST_SYNC);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Directed bench for rx_sync_ctrl: a vector table for lock/RD/error behaviour,
// then hand sequences for backpressure, bad-counter recovery, counter saturation and async reset.
module tb_rx_sync_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] sym_in;
    logic       sym_valid;
    logic       sym_ready;
    logic [9:0] sym_out;
    logic       rd_out;
    logic       out_valid;
    logic       out_ready;
    logic       sync;
    logic       code_err;
    logic       disp_err;
    logic [7:0] err_cnt;
    logic       clr_cnt;
    logic [1:0] state_dbg;

    localparam logic [9:0] K_NEG = 10'b0011111010;
    localparam logic [9:0] K_POS = 10'b1100000101;
    localparam logic [9:0] D00   = 10'b1001110100;
    localparam logic [9:0] BAD1  = 10'b1111111111;
    localparam logic [9:0] BAD0  = 10'b0000000000;
    localparam logic [9:0] SIX   = 10'b1111110000;

    rx_sync_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .sym_in    (sym_in),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_out   (sym_out),
        .rd_out    (rd_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sync      (sync),
        .code_err  (code_err),
        .disp_err  (disp_err),
        .err_cnt   (err_cnt),
        .clr_cnt   (clr_cnt),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [9:0] sym;
        logic       valid;
        logic       ordy;
        logic       clr;
        logic       e_ov;
        logic [9:0] e_sym;
        logic       e_rdo;
        logic       e_sync;
        logic       e_ce;
        logic       e_de;
        logic [1:0] e_state;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle; exp_err marks an accepted erroneous symbol for the counter model.
    task automatic drive(input logic [9:0] s, input logic v, input logic ordy,
                         input logic clr, input logic exp_err);
        sym_in    = s;
        sym_valid = v;
        out_ready = ordy;
        clr_cnt   = clr;
`ifdef RX_ERR_CNT_EN
        if (clr) exp_cnt = 0;
        else if (exp_err && exp_cnt < 255) exp_cnt++;
`else
        exp_cnt = 0;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{K_NEG, 1, 1, 0, 0, 10'd0, 0, 0, 0, 0, 2'd1};
        tbl[1]  = '{K_POS, 1, 1, 0, 0, 10'd0, 0, 0, 0, 0, 2'd2};
        tbl[2]  = '{K_NEG, 1, 1, 0, 0, 10'd0, 0, 1, 0, 0, 2'd3};
        tbl[3]  = '{D00,   1, 1, 0, 1, D00,   1, 1, 0, 0, 2'd3};
        tbl[4]  = '{K_POS, 1, 1, 0, 1, K_POS, 1, 1, 0, 0, 2'd3};
        tbl[5]  = '{D00,   1, 1, 0, 1, D00,   0, 1, 0, 0, 2'd3};
        tbl[6]  = '{BAD1,  1, 1, 0, 1, BAD1,  0, 1, 1, 0, 2'd3};
        tbl[7]  = '{SIX,   1, 1, 0, 1, SIX,   0, 1, 0, 0, 2'd3};
        tbl[8]  = '{SIX,   1, 1, 0, 1, SIX,   1, 1, 0, 1, 2'd3};
        tbl[9]  = '{D00,   0, 1, 0, 0, 10'd0, 0, 1, 0, 0, 2'd3};
        tbl[10] = '{BAD0,  1, 1, 0, 1, BAD0,  1, 0, 1, 0, 2'd0};
        tbl[11] = '{D00,   1, 1, 0, 0, 10'd0, 0, 0, 0, 0, 2'd0};
        tbl[12] = '{D00,   0, 1, 1, 0, 10'd0, 0, 0, 0, 0, 2'd0};
        tbl[13] = '{BAD1,  1, 1, 0, 0, 10'd0, 0, 0, 1, 0, 2'd0};
        tbl[14] = '{BAD1,  1, 1, 1, 0, 10'd0, 0, 0, 1, 0, 2'd0};
        tbl[15] = '{K_NEG, 1, 1, 0, 0, 10'd0, 0, 0, 0, 1, 2'd0};
        tbl[16] = '{K_POS, 1, 1, 0, 0, 10'd0, 0, 0, 0, 0, 2'd1};
        tbl[17] = '{BAD1,  1, 1, 0, 0, 10'd0, 0, 0, 1, 0, 2'd0};
        tbl[18] = '{K_NEG, 1, 1, 0, 0, 10'd0, 0, 0, 0, 0, 2'd1};
        tbl[19] = '{K_POS, 1, 1, 0, 0, 10'd0, 0, 0, 0, 0, 2'd2};
        tbl[20] = '{K_NEG, 1, 1, 0, 0, 10'd0, 0, 1, 0, 0, 2'd3};

        rst = 1'b0; sym_in = 10'd0; sym_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sym_out", sym_out, 0);
        chk("rst_rd_out", rd_out, 0);
        chk("rst_sync", sync, 0);
        chk("rst_code_err", code_err, 0);
        chk("rst_disp_err", disp_err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_state", state_dbg, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rel_sym_ready", sym_ready, 1);

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].sym, tbl[i].valid, tbl[i].ordy, tbl[i].clr,
                  tbl[i].valid & (tbl[i].e_ce | tbl[i].e_de));
            chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) begin
                chk($sformatf("v%0d_sym_out", i), sym_out, tbl[i].e_sym);
                chk($sformatf("v%0d_rd_out", i), rd_out, tbl[i].e_rdo);
            end
            chk($sformatf("v%0d_sync", i), sync, tbl[i].e_sync);
            chk($sformatf("v%0d_code_err", i), code_err, tbl[i].e_ce);
            chk($sformatf("v%0d_disp_err", i), disp_err, tbl[i].e_de);
            chk($sformatf("v%0d_state", i), state_dbg, tbl[i].e_state);
            chk($sformatf("v%0d_err_cnt", i), err_cnt, exp_cnt);
        end

        // Backpressure: locked, RD=1, output empty.
        sym_in = D00; sym_valid = 1'b1; out_ready = 1'b0; #1;
        chk("bp_ready_empty", sym_ready, 1);
        drive(D00, 1, 0, 0, 0);
        chk("bp_first_valid", out_valid, 1);
        chk("bp_first_sym", sym_out, D00);
        chk("bp_first_rd", rd_out, 1);
        chk("bp_ready_full", sym_ready, 0);
        for (int k = 0; k < 2; k++) begin
            drive(K_POS, 1, 0, 0, 0);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_sym", sym_out, D00);
            chk("bp_hold_rd", rd_out, 1);
            chk("bp_hold_ready", sym_ready, 0);
        end
        out_ready = 1'b1; #1;
        chk("bp_ready_drain", sym_ready, 1);
        drive(K_POS, 1, 1, 0, 0);
        chk("bp_swap_valid", out_valid, 1);
        chk("bp_swap_sym", sym_out, K_POS);
        chk("bp_swap_rd", rd_out, 1);
        drive(D00, 1, 1, 0, 0);
        chk("bp_b2b_valid", out_valid, 1);
        chk("bp_b2b_sym", sym_out, D00);
        chk("bp_b2b_rd", rd_out, 0);
        drive(D00, 0, 1, 0, 0);
        chk("bp_empty_valid", out_valid, 0);

        // Bad counter: an error, four good symbols clear it, then three errors drop lock.
        drive(BAD1, 1, 1, 0, 1);
        chk("bc_sync_a", sync, 1);
        for (int k = 0; k < 4; k++) drive(D00, 1, 1, 0, 0);
        chk("bc_sync_b", sync, 1);
        drive(BAD1, 1, 1, 0, 1);
        drive(BAD1, 1, 1, 0, 1);
        chk("bc_sync_c", sync, 1);
        chk("bc_rd_out", rd_out, 0);
        drive(BAD1, 1, 1, 0, 1);
        chk("bc_sync_lost", sync, 0);
        chk("bc_state_los", state_dbg, 0);
        chk("bc_last_fwd", out_valid, 1);
        chk("bc_err_cnt", err_cnt, exp_cnt);

        // Counter saturation and clear-over-increment.
        for (int k = 0; k < 300; k++) drive(BAD1, 1, 1, 0, 1);
        chk("sat_err_cnt", err_cnt, exp_cnt);
        drive(BAD1, 1, 1, 1, 1);
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_code_err", code_err, 1);

        // Re-lock from RD=0, leave a word pending, then reset asynchronously.
        drive(K_NEG, 1, 1, 0, 0);
        drive(K_POS, 1, 1, 0, 0);
        drive(K_NEG, 1, 1, 0, 0);
        chk("rl_sync", sync, 1);
        drive(D00, 1, 0, 0, 0);
        chk("rl_pending", out_valid, 1);
        sym_valid = 1'b0;
        #2;
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_sym_out", sym_out, 0);
        chk("ar_rd_out", rd_out, 0);
        chk("ar_sync", sync, 0);
        chk("ar_state", state_dbg, 0);
        chk("ar_err_cnt", err_cnt, 0);
        chk("ar_code_err", code_err, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("ar_sym_ready", sym_ready, 1);
        chk("ar_out_valid_after", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
